// File: rtl/stage_execute_mc.sv
// Parametrised execute stage with an iterative multiply/divide unit that stalls the pipeline itself.
// Optional macro STAGE_EXECUTE_MC_DIV_EN builds the divider for ops A/B; without it those ops return 0 in one cycle.
module stage_execute_mc #(
  parameter int XLEN     = 32,
  parameter int REG_BITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [XLEN-1:0]     pc,
  input  logic                stall_in,
  output logic                stall,
  input  logic [REG_BITS-1:0] dest,
  input  logic [3:0]          aluop,
  input  logic [XLEN-1:0]     reg_a,
  input  logic [XLEN-1:0]     reg_b,
  input  logic [XLEN-1:0]     reg_m,
  input  logic                is_mem_in,
  input  logic                mem_write_in,
  input  logic                is_jump,
  output logic                fwd_valid,
  output logic [REG_BITS-1:0] fwd_addr,
  output logic [XLEN-1:0]     fwd_val,
  output logic                jump,
  output logic [XLEN-1:0]     jump_addr,
  output logic [REG_BITS-1:0] out_addr,
  output logic [XLEN-1:0]     out_val,
  output logic                is_mem,
  output logic                mem_write,
  output logic [XLEN-1:0]     mem_addr,
  output logic [XLEN-1:0]     mem_val
);

  localparam int SHW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q, state_d;
  logic [SHW-1:0]  cnt_q, cnt_d;
  logic [3:0]      op_q, op_d;
  logic [XLEN-1:0] opnd_q, opnd_d;
  logic [XLEN-1:0] hi_q, hi_d;
  logic [XLEN-1:0] lo_q, lo_d;

  logic [REG_BITS-1:0] out_addr_q, out_addr_d;
  logic [XLEN-1:0]     out_val_q, out_val_d;
  logic                is_mem_q, is_mem_d;
  logic                mem_write_q, mem_write_d;
  logic [XLEN-1:0]     mem_addr_q, mem_addr_d;
  logic [XLEN-1:0]     mem_val_q, mem_val_d;

  logic            is_mc_op;
  logic            self_stall;
  logic [XLEN-1:0] a_s, b_s, alu_res, mc_res, addr_sum;
  logic [3:0]      op_s;
  logic [SHW-1:0]  shamt;
  logic [XLEN:0]   mul_sum;
`ifdef STAGE_EXECUTE_MC_DIV_EN
  logic [XLEN:0]   div_r;
  logic [XLEN-1:0] div_diff;
  logic            div_ge;
`endif

  assign addr_sum  = reg_a + reg_b;
  assign jump      = is_jump;
  assign jump_addr = addr_sum;
  assign fwd_addr  = dest;

  // Jumps reuse the adder to produce the return address pc + 4.
  assign a_s   = is_jump ? pc : reg_a;
  assign b_s   = is_jump ? XLEN'(4) : reg_b;
  assign op_s  = is_jump ? 4'd0 : aluop;
  assign shamt = b_s[SHW-1:0];

  always_comb begin
    alu_res = '0;
    case (op_s)
      4'h0: alu_res = a_s + b_s;
      4'h1: alu_res = a_s - b_s;
      4'h2: alu_res = a_s & b_s;
      4'h3: alu_res = a_s | b_s;
      4'h4: alu_res = a_s ^ b_s;
      4'h5: alu_res = a_s << shamt;
      4'h6: alu_res = a_s >> shamt;
      4'h7: alu_res = XLEN'($signed(a_s) >>> shamt);
      4'hC: alu_res = XLEN'($signed(a_s) < $signed(b_s));
      4'hD: alu_res = XLEN'(a_s < b_s);
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    is_mc_op = 1'b0;
    if (!is_jump && !is_mem_in) begin
`ifdef STAGE_EXECUTE_MC_DIV_EN
      is_mc_op = (aluop[3:2] == 2'b10);
`else
      is_mc_op = (aluop[3:1] == 3'b100);
`endif
    end
  end

  // Multiply: hi:lo holds partial product with multiplier shifting out of lo.
  assign mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
`ifdef STAGE_EXECUTE_MC_DIV_EN
  // Restoring divide: hi is the remainder, lo shifts dividend out and quotient in.
  // A zero divisor always "fits", which yields all-ones quotient and remainder = dividend.
  assign div_r    = {hi_q, lo_q[XLEN-1]};
  assign div_ge   = (div_r >= {1'b0, opnd_q});
  assign div_diff = div_r[XLEN-1:0] - opnd_q;
`endif

  always_comb begin
    mc_res = '0;
    case (op_q)
      4'h8: mc_res = lo_q;
      4'h9: mc_res = hi_q;
`ifdef STAGE_EXECUTE_MC_DIV_EN
      4'hA: mc_res = lo_q;
      4'hB: mc_res = hi_q;
`endif
      default: mc_res = '0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    opnd_d     = opnd_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    self_stall = 1'b0;
    case (state_q)
      IDLE: begin
        if (is_mc_op) begin
          self_stall = 1'b1;
          op_d       = aluop;
          cnt_d      = SHW'(XLEN - 1);
          state_d    = RUN;
          hi_d       = '0;
          lo_d       = reg_b;
          opnd_d     = reg_a;
`ifdef STAGE_EXECUTE_MC_DIV_EN
          if (aluop[1]) begin
            lo_d   = reg_a;
            opnd_d = reg_b;
          end
`endif
        end
      end
      RUN: begin
        self_stall = 1'b1;
        hi_d       = mul_sum[XLEN:1];
        lo_d       = {mul_sum[0], lo_q[XLEN-1:1]};
`ifdef STAGE_EXECUTE_MC_DIV_EN
        if (op_q[1]) begin
          hi_d = div_ge ? div_diff : div_r[XLEN-1:0];
          lo_d = {lo_q[XLEN-2:0], div_ge};
        end
`endif
        if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - SHW'(1);
        end
      end
      DONE: begin
        if (!stall_in) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign stall     = stall_in | self_stall;
  assign fwd_val   = (state_q == DONE) ? mc_res : alu_res;
  assign fwd_valid = (state_q == DONE) | (~self_stall & ~is_mem_in);

  always_comb begin
    out_addr_d  = out_addr_q;
    out_val_d   = out_val_q;
    is_mem_d    = is_mem_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_val_d   = mem_val_q;
    if (!stall) begin
      out_addr_d  = dest;
      out_val_d   = fwd_val;
      is_mem_d    = is_mem_in;
      mem_write_d = mem_write_in;
      mem_addr_d  = addr_sum;
      mem_val_d   = reg_m;
    end else if (!stall_in) begin
      // Self-stall: push a bubble downstream, memory address/data keep their last values.
      out_addr_d  = '0;
      out_val_d   = '0;
      is_mem_d    = 1'b0;
      mem_write_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      op_q        <= '0;
      opnd_q      <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      out_addr_q  <= '0;
      out_val_q   <= '0;
      is_mem_q    <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_val_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      opnd_q      <= opnd_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      out_addr_q  <= out_addr_d;
      out_val_q   <= out_val_d;
      is_mem_q    <= is_mem_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_val_q   <= mem_val_d;
    end
  end

  assign out_addr  = out_addr_q;
  assign out_val   = out_val_q;
  assign is_mem    = is_mem_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_val   = mem_val_q;

endmodule
